// File: rtl/mem_bd_pkg.sv
// mem_bd_pkg: shared state and command encodings for the memory backdoor controller
package mem_bd_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, RD_REQ, RD_WAIT, RD_OUT} mem_bd_state_t;
  localparam logic MEM_BD_LOAD = 1'b0;
  localparam logic MEM_BD_DUMP = 1'b1;
endpackage

// File: rtl/mem_bd_if.sv
// mem_bd_if: command, load/dump stream and memory port bundle of the backdoor controller
interface mem_bd_if #(
  parameter int REG_WIDTH  = 8,
  parameter int ADDR_WIDTH = 16
);
  logic                  cmd_valid, cmd_ready, cmd_op;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [ADDR_WIDTH:0]   cmd_len;
  logic                  in_valid, in_ready;
  logic [REG_WIDTH-1:0]  in_data;
  logic                  out_valid, out_ready;
  logic [REG_WIDTH-1:0]  out_data;
  logic [ADDR_WIDTH-1:0] out_addr;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [REG_WIDTH-1:0]  mem_wdata, mem_rdata;
  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_len, in_valid, in_data, out_ready, mem_rdata,
    input  cmd_ready, in_ready, out_valid, out_data, out_addr, mem_we, mem_addr, mem_wdata
  );
  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_len, in_valid, in_data, out_ready, mem_rdata,
    output cmd_ready, in_ready, out_valid, out_data, out_addr, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_bd_addr_cnt.sv
// mem_bd_addr_cnt: word address / remaining-count pair stepped once per transferred word
module mem_bd_addr_cnt #(
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  step,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic [ADDR_WIDTH:0]   load_len,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [ADDR_WIDTH:0]   remaining,
  output logic                  last
);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      addr      <= '0;
      remaining <= '0;
    end else if (load) begin
      addr      <= load_addr;
      remaining <= load_len;
    end else if (step) begin
      addr      <= addr + 1'b1;
      remaining <= remaining - 1'b1;
    end
  assign last = remaining == (ADDR_WIDTH+1)'(1);
endmodule

// File: rtl/mem_backdoor_ctrl.sv
// mem_backdoor_ctrl: loads or dumps a memory region through a single-port RAM while the CPU is halted
module mem_backdoor_ctrl
  import mem_bd_pkg::*;
#(
  parameter int REG_WIDTH  = 8,
  parameter int MEM_DEPTH  = 65536,
  parameter int ADDR_WIDTH = $clog2(MEM_DEPTH)
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   cpu_halted,
  input  logic   abort,
  mem_bd_if.slave bus,
  output logic   busy,
  output logic   done,
  output logic   err
);
  mem_bd_state_t         state;
  logic [ADDR_WIDTH-1:0] addr;
  logic [ADDR_WIDTH:0]   remaining;
  logic [ADDR_WIDTH+1:0] cmd_end;
  logic                  last, go, cmd_ok, accept, wr, xfer;
  mem_bd_addr_cnt #(.ADDR_WIDTH(ADDR_WIDTH)) u_cnt (
    .clk, .reset,
    .load(accept && cmd_ok), .step(wr || xfer),
    .load_addr(bus.cmd_addr), .load_len(bus.cmd_len),
    .addr, .remaining, .last
  );
  // extra bit keeps addr+len from wrapping so the full-range bound check is exact
  assign cmd_end = {2'b0, bus.cmd_addr} + {1'b0, bus.cmd_len};
  assign cmd_ok  = cpu_halted && bus.cmd_len != '0 && cmd_end <= (ADDR_WIDTH+2)'(MEM_DEPTH);
  assign go      = cpu_halted && !abort;
  assign bus.cmd_ready = state == IDLE;
  assign busy          = state != IDLE;
  assign accept        = bus.cmd_valid && bus.cmd_ready;
  // abort or halt loss block the data handshake in the same cycle
  assign bus.in_ready  = state == LOAD && go;
  assign bus.out_valid = state == RD_OUT && go;
  assign wr            = bus.in_valid && bus.in_ready;
  assign xfer          = bus.out_valid && bus.out_ready;
  assign bus.mem_we    = wr;
  assign bus.mem_addr  = addr;
  assign bus.mem_wdata = bus.in_data;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state        <= IDLE;
      done         <= 1'b0;
      err          <= 1'b0;
      bus.out_data <= '0;
      bus.out_addr <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE:
          if (accept) begin
            err   <= !cmd_ok;
            state <= !cmd_ok ? IDLE : bus.cmd_op == MEM_BD_DUMP ? RD_REQ : LOAD;
          end
        default:
          if (abort) state <= IDLE;
          else if (!cpu_halted) begin
            state <= IDLE;
            err   <= 1'b1;
          end else
            case (state)
              LOAD:
                if (wr && last) begin
                  state <= IDLE;
                  done  <= 1'b1;
                end
              RD_REQ: state <= RD_WAIT;
              RD_WAIT: begin
                bus.out_data <= bus.mem_rdata;
                bus.out_addr <= addr;
                state        <= RD_OUT;
              end
              RD_OUT:
                if (xfer) begin
                  state <= remaining > (ADDR_WIDTH+1)'(1) ? RD_REQ : IDLE;
                  done  <= last;
                end
              default: state <= IDLE;
            endcase
      endcase
    end
endmodule
